sdram_if_bram_responder: RTL and testbench
==========================================

// Module: sdram_if_bram_responder
// PURPOSE
// Responder side of the SDRAM MemoryController user handshake (read_a/read_b/write/refresh, busy, mask),
// backed by on-chip byte-writable BRAM. Drop-in substitute for the SDRAM controller under DRAM_conRV-style
// initiators on boards without SDRAM and in fast simulation; reproduces busy timing, init phase and refresh.
// PARAMETERS
// ADDR_WIDTH   12  word-address bits; capacity 2**ADDR_WIDTH x 32-bit words
// RD_LATENCY   4   cycles busy is high for a read (>=1)
// WR_LATENCY   3   cycles busy is high for a write (>=1)
// REF_CYCLES   8   cycles busy is high for a refresh (>=1)
// INIT_CLEAR   1   1: zero every word after reset (busy high during clear); 0: single-cycle init
// PORTS
// clk            in   1   sole clock
// rst_x          in   1   asynchronous reset, active low
// read_a         in   1   read request, result on dout_a
// read_b         in   1   read request, result on dout_b
// write          in   1   write request
// refresh        in   1   refresh request (timing only, no data effect)
// addr           in   32  byte address; addr[1:0] ignored, word = addr[ADDR_WIDTH+1:2]
// din            in   32  write data
// mask           in   4   byte-lane mask, ACTIVE LOW: mask[i]==0 writes din[8i+7:8i]
// dout_a         out  32  read data, port a
// dout_b         out  32  read data, port b
// busy           out  1   operation/init in progress
// mem_initialized out 1   init phase finished
// fail           out  1   sticky protocol/range error
// total_written  out  32  count of completed write operations (wraps)
// BEHAVIOUR
// - Reset values: busy=1, mem_initialized=0, fail=0, dout_a=0, dout_b=0, total_written=0, state=INIT.
//   RAM contents not reset. Reset mid-operation aborts it; a pending write is NOT committed.
// - States: INIT -> IDLE; IDLE -> RD_A | RD_B | WR | REF -> IDLE. All outputs registered.
// - INIT: INIT_CLEAR=1 writes 0 to words 0..2**ADDR_WIDTH-1, one per cycle; INIT_CLEAR=0 lasts 1 cycle.
//   Leaving INIT: busy->0 and mem_initialized->1 on the same edge; mem_initialized stays 1 until reset.
//   Requests during INIT are ignored (not queued).
// - IDLE (busy=0): requests sampled every edge; priority write > read_a > read_b > refresh.
//   addr/din/mask captured on accept edge T; busy=1 from T+1 for LAT cycles, falls at edge T+LAT.
// - Read: dout_x updated on the edge busy falls, held until next read on same port; other port unchanged.
// - Write: lanes with mask[i]==0 committed on the edge busy falls; total_written+1 on same edge.
//   mask==4'hF is a legal no-op write (still counted, still busy).
// - Refresh: busy for REF_CYCLES, no data change.
// - After busy falls, block stays IDLE >=1 cycle; a request still asserted then is accepted as new.
// - Request inputs ignored while busy (initiator must drop them after seeing busy).
// - fail (sticky until reset) set on: >1 of {read_a,read_b,write,refresh} at accept edge (highest wins);
//   addr[31:ADDR_WIDTH+2] != 0 at accept (access performed, busy timing normal, but write suppressed,
//   read returns 32'h0).
// - Latency counter width $clog2(max latency)+1; no combinational path input->output.
// STRUCTURE
// - Package sdram_if_resp_pkg: state enum (INIT, IDLE, RD_A, RD_B, WR, REF), request-code constants.
// - Sub-module bram_be32: single-port 32-bit RAM, 4 byte enables, synchronous read (1 cycle), inferable.
//   Read issued one cycle before busy falls so data lands exactly on the falling edge.
// - Top: FSM, latency counter, init address counter, capture registers, fail/total_written logic.
// TESTING
// - Reset, INIT_CLEAR=1, ADDR_WIDTH=4: busy=1 for 16 cycles after rst_x rises, then busy=0, mem_initialized=1;
//   read_a @0x3C -> dout_a=0.
// - write addr=0x10 din=0xA1B2C3D4 mask=4'h0, then read_a 0x12 -> busy high exactly RD_LATENCY cycles,
//   dout_a=0xA1B2C3D4 on falling edge; total_written=1.
// - write addr=0x10 din=0x000000EE mask=4'b1110 (byte 0 only) then read_b 0x10 -> dout_b=0xA1B2C3EE,
//   dout_a unchanged.
// - read_a and write asserted same cycle -> write executed, fail=1 and stays 1 through later good accesses.
// - addr=0x0001_0000 write 0xFFFFFFFF (ADDR_WIDTH=4) -> fail=1, word 0 unchanged; read there -> 0.
// - refresh -> busy high REF_CYCLES cycles, no data change; rst_x low mid-write -> busy=1 immediately,
//   target word unchanged after re-init with INIT_CLEAR=0.

Source files
------------

// File: rtl/sdram_if_resp_pkg.sv
// Shared types and constants for the BRAM-backed SDRAM-handshake responder.
package sdram_if_resp_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD_A  = 3'd2,
        ST_RD_B  = 3'd3,
        ST_WR    = 3'd4,
        ST_REF   = 3'd5
    } state_e;

    // Request vector layout: {write, read_a, read_b, refresh}, listed in priority order
    localparam logic [3:0] REQ_WRITE   = 4'b1000;
    localparam logic [3:0] REQ_READ_A  = 4'b0100;
    localparam logic [3:0] REQ_READ_B  = 4'b0010;
    localparam logic [3:0] REQ_REFRESH = 4'b0001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [2:0] req_count(input logic [3:0] req);
        return {2'b00, req[3]} + {2'b00, req[2]} + {2'b00, req[1]} + {2'b00, req[0]};
    endfunction

endpackage

// File: rtl/bram_be32.sv
// Single-port 32-bit RAM with per-byte write enables and one-cycle registered read.
module bram_be32 #(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o
);

    localparam int DEPTH = 2 ** AW;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes and read-first synchronous read
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_if_bram_responder.sv
// SDRAM-controller-compatible responder: busy/latency emulation in front of a byte-writable BRAM.
module sdram_if_bram_responder
    import sdram_if_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 3,
    parameter int REF_CYCLES = 8,
    parameter int INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        read_a,
    input  logic        read_b,
    input  logic        write,
    input  logic        refresh,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  mask,
    output logic [31:0] dout_a,
    output logic [31:0] dout_b,
    output logic        busy,
    output logic        mem_initialized,
    output logic        fail,
    output logic [31:0] total_written
);

    localparam int MAX_LAT = max3(RD_LATENCY, WR_LATENCY, REF_CYCLES);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           din_q, din_d;
    logic [3:0]            mask_q, mask_d;
    logic                  oor_q, oor_d;
    logic                  busy_q, busy_d;
    logic                  init_done_q, init_done_d;
    logic                  fail_q, fail_d;
    logic [31:0]           dout_a_q, dout_a_d;
    logic [31:0]           dout_b_q, dout_b_d;
    logic [31:0]           total_q, total_d;

    logic [3:0]            req_s;
    logic                  oor_s;
    logic [ADDR_WIDTH-1:0] word_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [31:0]           ram_wdata_s;
    logic [3:0]            ram_be_s;
    logic [31:0]           ram_rdata_s;

    assign req_s  = {write, read_a, read_b, refresh};
    assign oor_s  = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign word_s = addr[ADDR_WIDTH+1:2];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_addr_q <= '0;
            addr_q      <= '0;
            din_q       <= 32'd0;
            mask_q      <= 4'hF;
            oor_q       <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            fail_q      <= 1'b0;
            dout_a_q    <= 32'd0;
            dout_b_q    <= 32'd0;
            total_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_addr_q <= init_addr_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            mask_q      <= mask_d;
            oor_q       <= oor_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            fail_q      <= fail_d;
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            total_q     <= total_d;
        end
    end

    // Next-state, capture and RAM control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_addr_d = init_addr_q;
        addr_d      = addr_q;
        din_d       = din_q;
        mask_d      = mask_q;
        oor_d       = oor_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        fail_d      = fail_q;
        dout_a_d    = dout_a_q;
        dout_b_d    = dout_b_q;
        total_d     = total_q;
        ram_addr_s  = addr_q;
        ram_wdata_s = din_q;
        ram_be_s    = 4'h0;

        case (state_q)
            ST_INIT: begin
                ram_addr_s  = init_addr_q;
                ram_wdata_s = 32'd0;
                if (INIT_CLEAR != 0) begin
                    ram_be_s = 4'hF;
                    if (init_addr_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        init_addr_d = init_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    init_done_d = 1'b1;
                end
            end

            ST_IDLE: begin
                // Present the incoming address so a 1-cycle read already has data at the falling edge
                ram_addr_s = word_s;
                if (req_s != 4'b0000) begin
                    addr_d = word_s;
                    din_d  = din;
                    mask_d = mask;
                    oor_d  = oor_s;
                    busy_d = 1'b1;
                    if ((req_count(req_s) > 3'd1) || (oor_s && (req_s != REQ_REFRESH))) begin
                        fail_d = 1'b1;
                    end else begin
                        fail_d = fail_q;
                    end
                    if ((req_s & REQ_WRITE) != 4'b0000) begin
                        state_d = ST_WR;
                        cnt_d   = CNT_W'(WR_LATENCY - 1);
                    end else if ((req_s & REQ_READ_A) != 4'b0000) begin
                        state_d = ST_RD_A;
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                    end else if ((req_s & REQ_READ_B) != 4'b0000) begin
                        state_d = ST_RD_B;
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                    end else begin
                        state_d = ST_REF;
                        cnt_d   = CNT_W'(REF_CYCLES - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_A, ST_RD_B, ST_WR, ST_REF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (state_q == ST_RD_A) begin
                        dout_a_d = oor_q ? 32'd0 : ram_rdata_s;
                    end else if (state_q == ST_RD_B) begin
                        dout_b_d = oor_q ? 32'd0 : ram_rdata_s;
                    end else if (state_q == ST_WR) begin
                        ram_be_s = oor_q ? 4'h0 : ~mask_q;
                        total_d  = total_q + 32'd1;
                    end else begin
                        total_d = total_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    bram_be32 #(
        .AW(ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .be_i    (ram_be_s),
        .rdata_o (ram_rdata_s)
    );

    assign dout_a          = dout_a_q;
    assign dout_b          = dout_b_q;
    assign busy            = busy_q;
    assign mem_initialized = init_done_q;
    assign fail            = fail_q;
    assign total_written   = total_q;

endmodule

// File: tb/tb_sdram_if_bram_responder.sv
// Randomised self-checking bench for sdram_if_bram_responder against a word-array reference model.
module tb_sdram_if_bram_responder;

    localparam int AW   = 4;
    localparam int RDL  = 4;
    localparam int WRL  = 3;
    localparam int REFL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_x, read_a, read_b, write, refresh;
    logic [31:0] addr, din;
    logic [3:0]  mask;
    logic [31:0] dout_a, dout_b, total_written;
    logic        busy, mem_initialized, fail;

    logic        rst_x0, read_a0, write0;
    logic [31:0] addr0, din0;
    logic [31:0] dout_a0, dout_b0, total_written0;
    logic        busy0, mem_initialized0, fail0;

    sdram_if_bram_responder #(
        .ADDR_WIDTH(AW), .RD_LATENCY(RDL), .WR_LATENCY(WRL), .REF_CYCLES(REFL), .INIT_CLEAR(1)
    ) u_dut (
        .clk(clk), .rst_x(rst_x), .read_a(read_a), .read_b(read_b), .write(write),
        .refresh(refresh), .addr(addr), .din(din), .mask(mask), .dout_a(dout_a),
        .dout_b(dout_b), .busy(busy), .mem_initialized(mem_initialized), .fail(fail),
        .total_written(total_written)
    );

    sdram_if_bram_responder #(
        .ADDR_WIDTH(AW), .RD_LATENCY(RDL), .WR_LATENCY(WRL), .REF_CYCLES(REFL), .INIT_CLEAR(0)
    ) u_dut_noclr (
        .clk(clk), .rst_x(rst_x0), .read_a(read_a0), .read_b(1'b0), .write(write0),
        .refresh(1'b0), .addr(addr0), .din(din0), .mask(4'h0), .dout_a(dout_a0),
        .dout_b(dout_b0), .busy(busy0), .mem_initialized(mem_initialized0), .fail(fail0),
        .total_written(total_written0)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_mem [16];
    logic [31:0] m_da, m_db, m_tot;
    logic        m_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // req = {write, read_a, read_b, refresh}; called at a negedge with the DUT idle
    task automatic do_op(input string tag, input logic [3:0] req, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        int          lat;
        int          n;
        int          word;
        logic        oor;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        {write, read_a, read_b, refresh} = req;
        addr = a; din = d; mask = m;
        @(negedge clk);
        {write, read_a, read_b, refresh} = 4'b0000;

        word = int'(a[AW+1:2]);
        oor  = (a >> (AW + 2)) != 32'd0;
        if ($countones(req) > 1 || (oor && req != 4'b0001)) m_fail = 1'b1;
        if (req[3]) begin
            lat = WRL;
            if (!oor) begin
                for (int i = 0; i < 4; i++) begin
                    if (!m[i]) m_mem[word][8*i +: 8] = d[8*i +: 8];
                end
            end
            m_tot = m_tot + 32'd1;
        end else if (req[2]) begin
            lat  = RDL;
            m_da = oor ? 32'd0 : m_mem[word];
        end else if (req[1]) begin
            lat  = RDL;
            m_db = oor ? 32'd0 : m_mem[word];
        end else begin
            lat = REFL;
        end

        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(n), 32'(lat));
        check({tag, " dout_a"}, dout_a, m_da);
        check({tag, " dout_b"}, dout_b, m_db);
        check({tag, " fail"}, {31'd0, fail}, {31'd0, m_fail});
        check({tag, " total_written"}, total_written, m_tot);
    endtask

    task automatic wait_idle0(input string tag);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check({tag, " idle_timeout"}, {31'd0, busy0}, 32'd0);
    endtask

    task automatic op0(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
        write0 = w; read_a0 = ~w; addr0 = a; din0 = d;
        @(negedge clk);
        write0 = 1'b0; read_a0 = 1'b0;
        wait_idle0(tag);
    endtask

    initial begin
        int          n;
        logic [3:0]  req;
        logic [31:0] a;
        rst_x = 1'b0; rst_x0 = 1'b0;
        {write, read_a, read_b, refresh} = 4'b0000;
        addr = 32'd0; din = 32'd0; mask = 4'hF;
        write0 = 1'b0; read_a0 = 1'b0; addr0 = 32'd0; din0 = 32'd0;
        m_da = 32'd0; m_db = 32'd0; m_tot = 32'd0; m_fail = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;

        repeat (3) @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd1);
        check("rst mem_initialized", {31'd0, mem_initialized}, 32'd0);
        check("rst fail", {31'd0, fail}, 32'd0);
        check("rst dout_a", dout_a, 32'd0);
        check("rst dout_b", dout_b, 32'd0);
        check("rst total_written", total_written, 32'd0);

        rst_x = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 8) check("init mem_initialized mid", {31'd0, mem_initialized}, 32'd0);
        end
        check("init busy_cycles", 32'(n), 32'd16);
        check("init mem_initialized", {31'd0, mem_initialized}, 32'd1);

        do_op("rd_a_cleared", 4'b0100, 32'h0000_003C, 32'd0, 4'hF);
        do_op("wr_full", 4'b1000, 32'h0000_0010, 32'hA1B2_C3D4, 4'h0);
        do_op("rd_a_full", 4'b0100, 32'h0000_0012, 32'd0, 4'hF);
        do_op("wr_byte0", 4'b1000, 32'h0000_0010, 32'h0000_00EE, 4'b1110);
        do_op("rd_b_byte0", 4'b0010, 32'h0000_0010, 32'd0, 4'hF);
        do_op("wr_noop", 4'b1000, 32'h0000_0010, 32'h1111_1111, 4'hF);
        do_op("refresh", 4'b0001, 32'h0000_0010, 32'd0, 4'hF);
        do_op("rd_a_after_ref", 4'b0100, 32'h0000_0010, 32'd0, 4'hF);
        do_op("conflict_wr_rd", 4'b1100, 32'h0000_0020, 32'h5566_7788, 4'h0);
        do_op("rd_b_after_conf", 4'b0010, 32'h0000_0020, 32'd0, 4'hF);
        do_op("wr_oor", 4'b1000, 32'h0001_0000, 32'hFFFF_FFFF, 4'h0);
        do_op("rd_a_oor", 4'b0100, 32'h0001_0000, 32'd0, 4'hF);
        do_op("rd_b_word0", 4'b0010, 32'h0000_0000, 32'd0, 4'hF);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0, 1:    req = 4'b1000;
                2:       req = 4'b0100;
                3:       req = 4'b0010;
                default: req = 4'b0001;
            endcase
            if ($urandom_range(0, 9) == 0) req = req | 4'(1 << $urandom_range(0, 3));
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            do_op("random", req, a, $urandom, 4'($urandom_range(0, 15)));
        end

        rst_x0 = 1'b1;
        @(negedge clk);
        wait_idle0("noclr init");
        check("noclr rst dout_b", dout_b0, 32'd0);
        check("noclr rst fail", {31'd0, fail0}, 32'd0);
        op0("noclr wr", 1'b1, 32'h0000_0014, 32'hCAFE_F00D);
        check("noclr total_written", total_written0, 32'd1);
        op0("noclr rd", 1'b0, 32'h0000_0014, 32'd0);
        check("noclr rd data", dout_a0, 32'hCAFE_F00D);
        write0 = 1'b1; addr0 = 32'h0000_0014; din0 = 32'h1234_5678;
        @(negedge clk);
        write0 = 1'b0;
        @(negedge clk);
        rst_x0 = 1'b0;
        #1;
        check("noclr abort busy", {31'd0, busy0}, 32'd1);
        check("noclr abort mem_initialized", {31'd0, mem_initialized0}, 32'd0);
        check("noclr abort total_written", total_written0, 32'd0);
        @(negedge clk);
        rst_x0 = 1'b1;
        @(negedge clk);
        wait_idle0("noclr reinit");
        check("noclr reinit mem_initialized", {31'd0, mem_initialized0}, 32'd1);
        op0("noclr rd2", 1'b0, 32'h0000_0014, 32'd0);
        check("noclr word kept", dout_a0, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
